// File: rtl/seq_unlock_fsm.sv
// seq_unlock_fsm: parametrised sequence-unlock state machine.
// Matches a symbol stream against a key; repeated failures trigger a timed lockout.
module seq_unlock_fsm #(
    parameter int SYM_W          = 4,
    parameter int SEQ_LEN        = 4,
    parameter int TIMEOUT        = 16,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sym_valid,
    input  logic [SYM_W-1:0]             sym,
    input  logic [SEQ_LEN*SYM_W-1:0]     key,
    input  logic                         clear,
    output logic                         unlocked,
    output logic                         fail_pulse,
    output logic                         locked_out,
    output logic [$clog2(SEQ_LEN+1)-1:0] progress
);

    localparam int PW = $clog2(SEQ_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [PW-1:0] IDX_LAST  = PW'(SEQ_LEN - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

    // Binary encoding in 3 bits leaves spare codes that must fall into LOCKOUT.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MATCH    = 3'd1;
    localparam logic [2:0] S_UNLOCKED = 3'd2;
    localparam logic [2:0] S_LOCKOUT  = 3'd3;

    logic [2:0]       state_q, state_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic [TW-1:0]    idle_q, idle_d;
    logic [FW-1:0]    fail_cnt_q, fail_cnt_d;
    logic [LW-1:0]    lock_q, lock_d;

    logic             unlocked_q, unlocked_d;
    logic             fail_pulse_q, fail_pulse_d;
    logic             locked_out_q, locked_out_d;
    logic [PW-1:0]    progress_q, progress_d;

    logic [SYM_W-1:0] exp_sym;
    logic             sym_hit;
    logic             fail_ev;

    // Select the key slot the current attempt is waiting for.
    always_comb begin
        exp_sym = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (idx_q == PW'(i)) begin
                exp_sym = key[i*SYM_W +: SYM_W];
            end
        end
    end

    assign sym_hit = (sym == exp_sym);

    // State and registered outputs; reset returns everything to idle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            idle_q       <= '0;
            fail_cnt_q   <= '0;
            lock_q       <= '0;
            unlocked_q   <= 1'b0;
            fail_pulse_q <= 1'b0;
            locked_out_q <= 1'b0;
            progress_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            idle_q       <= idle_d;
            fail_cnt_q   <= fail_cnt_d;
            lock_q       <= lock_d;
            unlocked_q   <= unlocked_d;
            fail_pulse_q <= fail_pulse_d;
            locked_out_q <= locked_out_d;
            progress_q   <= progress_d;
        end
    end

    // Next-state logic: symbol matching, timeout, failure accounting, lockout.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        idle_d     = idle_q;
        fail_cnt_d = fail_cnt_q;
        lock_d     = lock_q;
        fail_ev    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (sym_valid) begin
                    if (sym_hit) begin
                        state_d = S_MATCH;
                        idx_d   = PW'(1);
                        idle_d  = '0;
                    end else begin
                        fail_ev = 1'b1;
                    end
                end
            end
            S_MATCH: begin
                // A valid symbol wins over an expiring idle timer.
                if (sym_valid) begin
                    if (sym_hit) begin
                        if (idx_q == IDX_LAST) begin
                            state_d    = S_UNLOCKED;
                            idx_d      = '0;
                            idle_d     = '0;
                            fail_cnt_d = '0;
                        end else begin
                            idx_d  = idx_q + PW'(1);
                            idle_d = '0;
                        end
                    end else begin
                        fail_ev = 1'b1;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    fail_ev = 1'b1;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
            S_UNLOCKED: begin
                if (clear) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (lock_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    lock_d = lock_q - LW'(1);
                end
            end
            default: begin
                // Corrupted state: fail secure by serving a full lockout.
                state_d    = S_LOCKOUT;
                lock_d     = LOCK_LOAD;
                idx_d      = '0;
                idle_d     = '0;
                fail_cnt_d = '0;
            end
        endcase

        // A failed attempt abandons progress; the last allowed one locks out.
        if (fail_ev) begin
            idx_d  = '0;
            idle_d = '0;
            if (fail_cnt_q == FAIL_LAST) begin
                state_d    = S_LOCKOUT;
                lock_d     = LOCK_LOAD;
                fail_cnt_d = '0;
            end else begin
                state_d    = S_IDLE;
                fail_cnt_d = fail_cnt_q + FW'(1);
            end
        end
    end

    // Output decode from the next state so the output registers track it.
    always_comb begin
        unlocked_d   = (state_d == S_UNLOCKED);
        locked_out_d = (state_d == S_LOCKOUT);
        fail_pulse_d = fail_ev;
        progress_d   = (state_d == S_MATCH) ? idx_d : '0;
    end

    assign unlocked   = unlocked_q;
    assign fail_pulse = fail_pulse_q;
    assign locked_out = locked_out_q;
    assign progress   = progress_q;

endmodule

// File: tb/tb_seq_unlock_fsm.sv
// tb_seq_unlock_fsm: directed scoreboard bench for seq_unlock_fsm.
// Driver queues expected outputs per cycle; monitor pops and compares.
module tb_seq_unlock_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sym_valid = 1'b0;
    logic [3:0]  sym = '0;
    logic [15:0] key = 16'h4321;
    logic        clear = 1'b0;
    logic        unlocked;
    logic        fail_pulse;
    logic        locked_out;
    logic [2:0]  progress;

    seq_unlock_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .key        (key),
        .clear      (clear),
        .unlocked   (unlocked),
        .fail_pulse (fail_pulse),
        .locked_out (locked_out),
        .progress   (progress)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       unl;
        logic       fl;
        logic       lk;
        logic [2:0] pg;
    } exp_t;

    exp_t  sb[$];
    exp_t  me;
    int    n_chk  = 0;
    int    n_pass = 0;
    string phase  = "init";

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic cyc(input logic v, input logic [3:0] s, input logic c,
                       input logic eu, input logic ef, input logic el,
                       input logic [2:0] ep);
        exp_t e;
        @(negedge clk);
        sym_valid = v;
        sym       = s;
        clear     = c;
        e.tag = phase;
        e.unl = eu;
        e.fl  = ef;
        e.lk  = el;
        e.pg  = ep;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [2:0] ep);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, ep);
    endtask

    task automatic unlock_seq();
        cyc(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        cyc(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        cyc(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
        cyc(1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(3'd0);
    endtask

    // Remaining 64 cycles after entering lockout; optional ignored traffic.
    task automatic lock_wait(input bit noise);
        for (int i = 1; i <= 64; i++) begin
            if (noise && i <= 4)
                cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
            else
                cyc(1'b0, 4'd0, noise && i == 5, 1'b0, 1'b0, i < 64, 3'd0);
        end
    endtask

    task automatic chk(input string nm, input logic [5:0] act,
                       input logic [5:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got {unl,fail,lock,prog}=%b required %b",
                     nm, act, exp);
    endtask

    // Monitor: compare outputs just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                me = sb.pop_front();
                n_chk++;
                if (unlocked === me.unl && fail_pulse === me.fl &&
                    locked_out === me.lk && progress === me.pg)
                    n_pass++;
                else
                    $display("FAIL %s @%0t: got unl=%b fail=%b lock=%b prog=%0d required unl=%b fail=%b lock=%b prog=%0d",
                             me.tag, $time, unlocked, fail_pulse, locked_out,
                             progress, me.unl, me.fl, me.lk, me.pg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        phase = "reset_state";
        chk("reset_state", {unlocked, fail_pulse, locked_out, progress}, 6'b0);
        rst = 1'b0;
        idle(3'd0);

        phase = "unlock";
        unlock_seq();

        phase = "mismatch";
        cyc(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        cyc(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        cyc(1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        phase = "unlock_after_fail";
        unlock_seq();

        phase = "three_fails";
        cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        phase = "lockout";
        lock_wait(1'b1);
        phase = "unlock_after_lockout";
        unlock_seq();

        phase = "timeout";
        cyc(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        for (int i = 1; i <= 15; i++) idle(3'd1);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        idle(3'd0);
        phase = "no_timeout";
        cyc(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        for (int i = 1; i <= 15; i++) idle(3'd1);
        cyc(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        cyc(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
        cyc(1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        phase = "slot0_mismatch";
        cyc(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        cyc(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        cyc(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        phase = "clear_in_match";
        cyc(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        cyc(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);

        @(negedge clk);
        sym_valid = 1'b0;
        clear     = 1'b0;
        rst       = 1'b1;
        #1;
        chk("async_rst_match", {unlocked, fail_pulse, locked_out, progress}, 6'b0);
        @(negedge clk);
        rst = 1'b0;

        phase = "fails_after_rst";
        cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_lockout", {unlocked, fail_pulse, locked_out, progress}, 6'b0);
        @(negedge clk);
        rst = 1'b0;
        phase = "unlock_after_rst";
        unlock_seq();

        @(negedge clk);
        force dut.state_q = 3'b111;
        #1;
        release dut.state_q;
        phase = "illegal_state";
        me.tag = phase;
        me.unl = 1'b0;
        me.fl  = 1'b0;
        me.lk  = 1'b1;
        me.pg  = 3'd0;
        sb.push_back(me);
        lock_wait(1'b0);
        phase = "unlock_after_illegal";
        unlock_seq();

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
